// File: rtl/cpu_v7.sv
// cpu_v7: 3-stage (fetch / execute / writeback) micro-CPU core with an external
// program ROM, a register file, a Z flag, I/O ports and wait/halt control.
// Defining CPU_CARRY_EN adds a carry flag C plus the ADC (0xD) and JC (0xE)
// opcodes. Without it, 0xD and 0xE execute as NOP and there is no C flop.
module cpu_v7 #(
  parameter int INSTR_WIDTH      = 24,
  parameter int INSTR_ADDR_WIDTH = 4,
  parameter int REG_ADDR_WIDTH   = 3,
  parameter int BUS_WIDTH        = 8,
  parameter int NUM_PORTS        = 2,
  parameter int PORT_SEL_WIDTH   = 1
) (
  input  logic                           clk,
  input  logic                           n_reset,
  output logic [INSTR_ADDR_WIDTH-1:0]    instr_addr,
  input  logic [INSTR_WIDTH-1:0]         instr,
  input  logic [NUM_PORTS*BUS_WIDTH-1:0] in_port,
  input  logic [NUM_PORTS-1:0]           ready_in,
  output logic [NUM_PORTS*BUS_WIDTH-1:0] out_port,
  output logic [NUM_PORTS-1:0]           out_valid,
  output logic                           halted
);
  localparam int NREG = 2**REG_ADDR_WIDTH;
  localparam int RW   = REG_ADDR_WIDTH;
  localparam logic [3:0] OP_LDI = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_AND = 4'h4,
                         OP_OR  = 4'h5, OP_XOR = 4'h6, OP_IN  = 4'h7, OP_OUT = 4'h8,
                         OP_JMP = 4'h9, OP_JZ  = 4'hA, OP_WTR = 4'hB, OP_WTP = 4'hC,
                         OP_ADC = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF;

  logic [INSTR_ADDR_WIDTH-1:0]        pc_q, pc_d;
  logic [INSTR_WIDTH-1:0]             ir_q, ir_d;
  logic [BUS_WIDTH-1:0]               rf_q [NREG];
  logic                               w_we_q, w_we_d, w_zwe_q, w_zwe_d, w_z_q, w_z_d, z_q;
  logic [RW-1:0]                      w_rd_q;
  logic [BUS_WIDTH-1:0]               w_res_q;
  logic [NUM_PORTS-1:0][BUS_WIDTH-1:0] in_s1_q, in_s2_q, out_q, out_d;
  logic [NUM_PORTS-1:0]               rdy_s1_q, rdy_s2_q, rdy_s3_q, vld_q, vld_d;
  logic                               halted_q, halted_d;

  // execute-stage decode
  logic [3:0]                  op;
  logic [RW-1:0]               rd, ra, rb;
  logic [BUS_WIDTH-1:0]        imm, ra_v, rb_v, res;
  logic [PORT_SEL_WIDTH-1:0]   p;
  logic                        p_ok, z_cur, we, zwe, take, stall, do_out, do_halt, freeze;
`ifdef CPU_CARRY_EN
  logic                        c_q, w_cwe_q, w_c_q, c_cur, cy, cwe;
`endif
  // bits between the register fields and imm carry no meaning
  logic                        unused_ir;

  assign op   = ir_q[INSTR_WIDTH-1 -: 4];
  assign rd   = ir_q[INSTR_WIDTH-5 -: RW];
  assign ra   = ir_q[INSTR_WIDTH-5-RW -: RW];
  assign rb   = ir_q[INSTR_WIDTH-5-2*RW -: RW];
  assign imm  = ir_q[BUS_WIDTH-1:0];
  assign p    = imm[PORT_SEL_WIDTH-1:0];
  assign p_ok = 32'(p) < NUM_PORTS;
  assign unused_ir = ^ir_q;

  // W->E forwarding of operands and flags
  assign ra_v  = (w_we_q && w_rd_q == ra) ? w_res_q : rf_q[ra];
  assign rb_v  = (w_we_q && w_rd_q == rb) ? w_res_q : rf_q[rb];
  assign z_cur = w_zwe_q ? w_z_q : z_q;
`ifdef CPU_CARRY_EN
  assign c_cur = w_cwe_q ? w_c_q : c_q;
`endif

  assign instr_addr = pc_q;
  assign out_port   = out_q;
  assign out_valid  = vld_q;
  assign halted     = halted_q;

  // execute the instruction in ir and form all next-state values
  always_comb begin
    res = '0; we = 1'b0; zwe = 1'b0; take = 1'b0; stall = 1'b0;
    do_out = 1'b0; do_halt = 1'b0;
`ifdef CPU_CARRY_EN
    cy = 1'b0; cwe = 1'b0;
`endif
    case (op)
      OP_LDI: begin res = imm; we = 1'b1; end
      OP_ADD: begin
`ifdef CPU_CARRY_EN
        {cy, res} = {1'b0, ra_v} + {1'b0, rb_v}; cwe = 1'b1;
`else
        res = ra_v + rb_v;
`endif
        we = 1'b1; zwe = 1'b1;
      end
      OP_SUB: begin
        res = ra_v - rb_v; we = 1'b1; zwe = 1'b1;
`ifdef CPU_CARRY_EN
        cy = ra_v < rb_v; cwe = 1'b1;
`endif
      end
      OP_AND: begin res = ra_v & rb_v; we = 1'b1; zwe = 1'b1; end
      OP_OR:  begin res = ra_v | rb_v; we = 1'b1; zwe = 1'b1; end
      OP_XOR: begin res = ra_v ^ rb_v; we = 1'b1; zwe = 1'b1; end
      OP_IN:  begin res = p_ok ? in_s2_q[p] : '0; we = 1'b1; end
      OP_OUT: do_out = p_ok;
      OP_JMP: take = 1'b1;
      OP_JZ:  take = z_cur;
      // a WAITP edge only counts while the WAITP sits in E
      OP_WTR: stall = p_ok && !rdy_s2_q[p];
      OP_WTP: stall = p_ok && !(rdy_s2_q[p] && !rdy_s3_q[p]);
`ifdef CPU_CARRY_EN
      OP_ADC: begin
        {cy, res} = {1'b0, ra_v} + {1'b0, rb_v} + {{BUS_WIDTH{1'b0}}, c_cur};
        we = 1'b1; zwe = 1'b1; cwe = 1'b1;
      end
      OP_JC:  take = c_cur;
`endif
      OP_HLT: do_halt = 1'b1;
      default: ;
    endcase
    if (halted_q) begin
      we = 1'b0; zwe = 1'b0; take = 1'b0; do_out = 1'b0; do_halt = 1'b0;
`ifdef CPU_CARRY_EN
      cwe = 1'b0;
`endif
    end
    freeze   = halted_q | do_halt | stall;
    pc_d     = freeze ? pc_q : (take ? imm[INSTR_ADDR_WIDTH-1:0] : pc_q + 1'b1);
    ir_d     = freeze ? ir_q : (take ? '0 : instr);
    w_we_d   = we;
    w_zwe_d  = zwe;
    w_z_d    = (res == '0);
    halted_d = halted_q | do_halt;
    out_d    = out_q;
    vld_d    = '0;
    if (do_out) begin
      out_d[p] = ra_v;
      vld_d[p] = 1'b1;
    end
  end

  // pipeline, register file, flags, synchronisers and output registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pc_q <= '0; ir_q <= '0; halted_q <= 1'b0; z_q <= 1'b0;
      w_we_q <= 1'b0; w_zwe_q <= 1'b0; w_z_q <= 1'b0; w_rd_q <= '0; w_res_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      in_s1_q <= '0; in_s2_q <= '0; rdy_s1_q <= '0; rdy_s2_q <= '0; rdy_s3_q <= '0;
      out_q <= '0; vld_q <= '0;
`ifdef CPU_CARRY_EN
      c_q <= 1'b0; w_cwe_q <= 1'b0; w_c_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d; ir_q <= ir_d; halted_q <= halted_d;
      if (w_we_q)  rf_q[w_rd_q] <= w_res_q;
      if (w_zwe_q) z_q <= w_z_q;
      w_we_q <= w_we_d; w_zwe_q <= w_zwe_d; w_z_q <= w_z_d; w_rd_q <= rd; w_res_q <= res;
      in_s1_q <= in_port;  in_s2_q <= in_s1_q;
      rdy_s1_q <= ready_in; rdy_s2_q <= rdy_s1_q; rdy_s3_q <= rdy_s2_q;
      out_q <= out_d; vld_q <= vld_d;
`ifdef CPU_CARRY_EN
      if (w_cwe_q) c_q <= w_c_q;
      w_cwe_q <= cwe; w_c_q <= cy;
`endif
    end
  end
endmodule

// File: tb/tb_cpu_v7.sv
// tb_cpu_v7: table-driven program vectors plus directed wait / halt / reset sequences.
module tb_cpu_v7;
  localparam logic [3:0] O_NOP = 4'h0, O_LDI = 4'h1, O_ADD = 4'h2, O_SUB = 4'h3, O_AND = 4'h4,
                         O_OR  = 4'h5, O_XOR = 4'h6, O_IN  = 4'h7, O_OUT = 4'h8, O_JMP = 4'h9,
                         O_JZ  = 4'hA, O_WTR = 4'hB, O_WTP = 4'hC, O_ADC = 4'hD, O_HLT = 4'hF;

  logic        clk, n_reset, halted;
  logic [3:0]  instr_addr;
  logic [23:0] instr;
  logic [15:0] in_port, out_port;
  logic [1:0]  ready_in, out_valid;
  logic [23:0] rom [16];

  int errs = 0, checks = 0;
  int n0, n1, cyc, first0;

  typedef struct {
    logic [11:0][23:0] prog;
    logic [15:0]       inp;
    logic [15:0]       exp_out;
    int                exp_n0, exp_n1, exp_first0;
  } vec_t;
  vec_t tbl [8];

  cpu_v7 dut (
    .clk(clk), .n_reset(n_reset), .instr_addr(instr_addr), .instr(instr),
    .in_port(in_port), .ready_in(ready_in), .out_port(out_port),
    .out_valid(out_valid), .halted(halted)
  );

  assign instr = rom[instr_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [7:0] imm);
    return {op, rd, ra, rb, 3'b000, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [11:0][23:0] prog);
    for (int i = 0; i < 16; i++) rom[i] = (i < 12) ? prog[i] : 24'h0;
  endtask

  // reset released just after a negedge, so the next posedge is edge 1
  task automatic do_reset();
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_reset = 1'b1;
    n0 = 0; n1 = 0; cyc = 0; first0 = -1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid[0]) begin
      n0++;
      if (first0 < 0) first0 = cyc;
    end
    if (out_valid[1]) n1++;
  endtask

  initial begin
    logic [11:0][23:0] pg;
    n_reset = 1'b0; in_port = '0; ready_in = '0;
    for (int i = 0; i < 8; i++) begin
      tbl[i].prog = '0; tbl[i].inp = '0;
    end
    // back-to-back forwarding: 5+3 -> port0
    tbl[0].prog[0] = enc(O_LDI,1,0,0,8'd5); tbl[0].prog[1] = enc(O_LDI,2,0,0,8'd3);
    tbl[0].prog[2] = enc(O_ADD,3,1,2,0);    tbl[0].prog[3] = enc(O_OUT,0,3,0,0);
    tbl[0].prog[4] = enc(O_HLT,0,0,0,0);
    tbl[0].exp_out = 16'h0008; tbl[0].exp_n0 = 1; tbl[0].exp_n1 = 0; tbl[0].exp_first0 = 5;
    // taken JZ flushes word 3, one bubble
    tbl[1].prog[0] = enc(O_LDI,1,0,0,8'd7); tbl[1].prog[1] = enc(O_SUB,2,1,1,0);
    tbl[1].prog[2] = enc(O_JZ,0,0,0,8'd6);  tbl[1].prog[3] = enc(O_OUT,0,1,0,0);
    tbl[1].prog[6] = enc(O_OUT,0,2,0,0);    tbl[1].prog[7] = enc(O_HLT,0,0,0,0);
    tbl[1].exp_out = 16'h0000; tbl[1].exp_n0 = 1; tbl[1].exp_n1 = 0; tbl[1].exp_first0 = 6;
    // IN from port1, OUT to port1, FF+01 wraps to 0 and sets Z
    tbl[2].prog[2] = enc(O_IN,1,0,0,8'd1);  tbl[2].prog[3] = enc(O_OUT,0,1,0,8'd1);
    tbl[2].prog[4] = enc(O_LDI,2,0,0,8'hFF); tbl[2].prog[5] = enc(O_LDI,3,0,0,8'h01);
    tbl[2].prog[6] = enc(O_ADD,4,2,3,0);    tbl[2].prog[7] = enc(O_JZ,0,0,0,8'd9);
    tbl[2].prog[8] = enc(O_OUT,0,2,0,0);    tbl[2].prog[9] = enc(O_OUT,0,4,0,0);
    tbl[2].prog[10] = enc(O_HLT,0,0,0,0);   tbl[2].inp = 16'hA53C;
    tbl[2].exp_out = 16'hA500; tbl[2].exp_n0 = 1; tbl[2].exp_n1 = 1; tbl[2].exp_first0 = 11;
    // logical ops: C3&5A=42, C3|5A=DB, C3^5A=99
    tbl[3].prog[0] = enc(O_LDI,1,0,0,8'hC3); tbl[3].prog[1] = enc(O_LDI,2,0,0,8'h5A);
    tbl[3].prog[2] = enc(O_AND,3,1,2,0);    tbl[3].prog[3] = enc(O_OR,4,1,2,0);
    tbl[3].prog[4] = enc(O_XOR,5,1,2,0);    tbl[3].prog[5] = enc(O_OUT,0,3,0,0);
    tbl[3].prog[6] = enc(O_OUT,0,5,0,8'd1); tbl[3].prog[7] = enc(O_OUT,0,4,0,0);
    tbl[3].prog[8] = enc(O_HLT,0,0,0,0);
    tbl[3].exp_out = 16'h99DB; tbl[3].exp_n0 = 2; tbl[3].exp_n1 = 1; tbl[3].exp_first0 = 7;
    // LDI between SUB and JZ leaves Z set
    tbl[4].prog[0] = enc(O_LDI,1,0,0,8'd1); tbl[4].prog[1] = enc(O_LDI,2,0,0,8'd1);
    tbl[4].prog[2] = enc(O_SUB,3,1,2,0);    tbl[4].prog[3] = enc(O_LDI,4,0,0,8'd9);
    tbl[4].prog[4] = enc(O_JZ,0,0,0,8'd6);  tbl[4].prog[5] = enc(O_OUT,0,4,0,0);
    tbl[4].prog[6] = enc(O_OUT,0,4,0,8'd1); tbl[4].prog[7] = enc(O_HLT,0,0,0,0);
    tbl[4].exp_out = 16'h0900; tbl[4].exp_n0 = 0; tbl[4].exp_n1 = 1; tbl[4].exp_first0 = -1;
    // not-taken JZ: no penalty
    tbl[5].prog[0] = enc(O_LDI,1,0,0,8'd1); tbl[5].prog[1] = enc(O_ADD,2,1,1,0);
    tbl[5].prog[2] = enc(O_JZ,0,0,0,8'd5);  tbl[5].prog[3] = enc(O_OUT,0,2,0,0);
    tbl[5].prog[4] = enc(O_HLT,0,0,0,0);    tbl[5].prog[5] = enc(O_OUT,0,2,0,8'd1);
    tbl[5].exp_out = 16'h0002; tbl[5].exp_n0 = 1; tbl[5].exp_n1 = 0; tbl[5].exp_first0 = 5;
    // 3-5 wraps to FE, JMP skips word 5
    tbl[6].prog[0] = enc(O_LDI,1,0,0,8'd3); tbl[6].prog[1] = enc(O_LDI,2,0,0,8'd5);
    tbl[6].prog[2] = enc(O_SUB,3,1,2,0);    tbl[6].prog[3] = enc(O_OUT,0,3,0,8'd1);
    tbl[6].prog[4] = enc(O_JMP,0,0,0,8'd6); tbl[6].prog[5] = enc(O_OUT,0,3,0,0);
    tbl[6].prog[6] = enc(O_HLT,0,0,0,0);
    tbl[6].exp_out = 16'hFE00; tbl[6].exp_n0 = 0; tbl[6].exp_n1 = 1; tbl[6].exp_first0 = -1;
    // ADC r5,r0,r0 right after a carrying ADD: 1 with carry, NOP (r5 stays 0) without
    tbl[7].prog[0] = enc(O_LDI,2,0,0,8'hFF); tbl[7].prog[1] = enc(O_LDI,3,0,0,8'h01);
    tbl[7].prog[2] = enc(O_ADD,4,2,3,0);    tbl[7].prog[3] = enc(O_ADC,5,0,0,0);
    tbl[7].prog[4] = enc(O_OUT,0,5,0,0);    tbl[7].prog[5] = enc(O_HLT,0,0,0,0);
`ifdef CPU_CARRY_EN
    tbl[7].exp_out = 16'h0001;
`else
    tbl[7].exp_out = 16'h0000;
`endif
    tbl[7].exp_n0 = 1; tbl[7].exp_n1 = 0; tbl[7].exp_first0 = 6;

    // reset state
    load(tbl[0].prog);
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", 32'(instr_addr), 0);
    chk("reset out_port", 32'(out_port), 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset halted", 32'(halted), 0);

    for (int v = 0; v < 8; v++) begin
      in_port = tbl[v].inp; ready_in = '0;
      load(tbl[v].prog);
      do_reset();
      repeat (24) step();
      chk($sformatf("v%0d out_port", v), 32'(out_port), 32'(tbl[v].exp_out));
      chk($sformatf("v%0d strobes p0", v), n0, tbl[v].exp_n0);
      chk($sformatf("v%0d strobes p1", v), n1, tbl[v].exp_n1);
      chk($sformatf("v%0d first p0 edge", v), first0, tbl[v].exp_first0);
      chk($sformatf("v%0d halted", v), 32'(halted), 1);
    end

    // WAITR p1: PC holds while ready is low; OUT retires on the 4th edge after rise
    pg = '0;
    pg[0] = enc(O_WTR,0,0,0,8'd1); pg[1] = enc(O_OUT,0,0,0,0); pg[2] = enc(O_HLT,0,0,0,0);
    load(pg); in_port = '0; ready_in = 2'b00;
    do_reset();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("waitr pc hold", 32'(instr_addr), 1);
    end
    chk("waitr no out", n0, 0);
    ready_in[1] = 1'b1;
    begin
      int k;
      k = 0;
      for (int i = 1; i <= 8 && k == 0; i++) begin
        step();
        if (out_valid[0]) k = i;
      end
      chk("waitr release edge", k, 4);
    end

    // WAITP p0 entered with ready already high: needs a fresh low->high
    pg = '0;
    pg[3] = enc(O_WTP,0,0,0,0); pg[4] = enc(O_OUT,0,0,0,0);
    pg[5] = enc(O_WTP,0,0,0,0); pg[6] = enc(O_OUT,0,0,0,8'd1); pg[7] = enc(O_HLT,0,0,0,0);
    load(pg); ready_in = 2'b01;
    do_reset();
    repeat (10) step();
    chk("waitp level ignored", n0, 0);
    chk("waitp pc hold", 32'(instr_addr), 4);
    ready_in[0] = 1'b0; repeat (3) step();
    ready_in[0] = 1'b1; repeat (8) step();
    chk("waitp one release p0", n0, 1);
    chk("waitp no release p1", n1, 0);
    chk("waitp second pc hold", 32'(instr_addr), 6);
    chk("waitp not halted", 32'(halted), 0);
    ready_in[0] = 1'b0; repeat (3) step();
    ready_in[0] = 1'b1; repeat (8) step();
    chk("waitp second release", n1, 1);
    chk("waitp halted", 32'(halted), 1);

    // HALT at 3, then asynchronous reset mid-cycle
    pg = '0;
    pg[0] = enc(O_LDI,1,0,0,8'h3C); pg[1] = enc(O_OUT,0,1,0,0);
    pg[3] = enc(O_HLT,0,0,0,0);     pg[4] = enc(O_OUT,0,1,0,8'd1);
    load(pg); ready_in = '0;
    do_reset();
    repeat (10) step();
    chk("halt halted", 32'(halted), 1);
    chk("halt pc frozen", 32'(instr_addr), 4);
    chk("halt out_port", 32'(out_port), 32'h003C);
    chk("halt no later out", n1, 0);
    #3 n_reset = 1'b0;
    #1;
    chk("async reset pc", 32'(instr_addr), 0);
    chk("async reset halted", 32'(halted), 0);
    chk("async reset out_port", 32'(out_port), 0);
    @(negedge clk);
    n_reset = 1'b1;
    step();
    chk("first fetch after reset", 32'(instr_addr), 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/cpu_v7.md
Name: cpu_v7

Overview:
- Next-generation micro-CPU core: 3-stage pipeline (fetch / execute / writeback).
- Adds parametrised register count, multiple I/O ports, logical and subtract ALU ops, and jumps with a zero flag.
- Forwarding, stall-on-wait and halt are included.
- Program ROM is external: the core drives instr_addr and receives instr combinationally.

Parameters:
- INSTR_WIDTH, 24, instruction width; must be >= 4+3*REG_ADDR_WIDTH+BUS_WIDTH.
- INSTR_ADDR_WIDTH, 4, PC width.
- REG_ADDR_WIDTH, 3, register count = 2**REG_ADDR_WIDTH.
- BUS_WIDTH, 8, datapath width.
- NUM_PORTS, 2, number of input ports and number of output ports.
- PORT_SEL_WIDTH, 1, port select width; NUM_PORTS <= 2**PORT_SEL_WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- instr_addr  output  INSTR_ADDR_WIDTH  PC to program ROM.
- instr  input  INSTR_WIDTH  ROM data, combinational from instr_addr.
- in_port  input  NUM_PORTS*BUS_WIDTH  packed input ports, asynchronous.
- ready_in  input  NUM_PORTS  per-port ready, asynchronous.
- out_port  output  NUM_PORTS*BUS_WIDTH  packed registered output ports.
- out_valid  output  NUM_PORTS  1-cycle strobe per output port.
- halted  output  1  high once HALT executes.

Behaviour:
- Instruction fields:
  - op = top 4 bits.
  - rd, ra, rb = next three REG_ADDR_WIDTH fields, in that order.
  - imm = instr[BUS_WIDTH-1:0].
  - p = imm[PORT_SEL_WIDTH-1:0].
  - target = imm[INSTR_ADDR_WIDTH-1:0].
- Opcodes:
  - 0 NOP.
  - 1 LDI: rd=imm.
  - 2 ADD: rd=ra+rb.
  - 3 SUB: rd=ra-rb.
  - 4 AND, 5 OR, 6 XOR: rd=ra op rb.
  - 7 IN: rd=in_sync[p].
  - 8 OUT: out_port[p]=ra.
  - 9 JMP: PC=target.
  - A JZ: jump if Z.
  - B WAITR: stall until ready_sync[p]=1.
  - C WAITP: stall until a rising edge of ready_sync[p].
  - D/E: see optional feature.
  - F HALT.
- Arithmetic: modulo 2**BUS_WIDTH. Z is set by ops 2-6 only; it is unchanged by all other ops.
- Input sync:
  - in_port and ready_in each pass through a 2-flop synchroniser.
  - Edge detect is ready_sync & ~ready_sync_q.
  - A WAITP edge counts only while WAITP is in E; earlier edges are lost.
- Fetch (F):
  - instr_addr = PC.
  - Each unstalled edge: ir<=instr, PC<=PC+1; PC wraps 2**INSTR_ADDR_WIDTH-1 -> 0.
- Execute (E):
  - Decode ir, read the register file, compute.
  - Result, rd and write-enable are registered into the W stage.
- Writeback (W):
  - The register file writes on the edge that retires W.
  - A W->E forward applies when W.we and W.rd matches ra/rb.
  - Z is forwarded the same way to JZ.
  - No other hazards exist.
- Jumps:
  - A taken JMP/JZ in E: at the edge PC<=target and ir<=NOP (flush).
  - Penalty is 1 bubble. A not-taken JZ has no penalty.
- Waits:
  - While the WAITR/WAITP condition is false, PC and ir hold and E sends a bubble to W.
  - When the condition becomes true, the instruction retires that cycle.
- OUT: at the E edge, out_port[p]<=ra (forwarded value) and out_valid[p] pulses for 1 cycle. Other ports hold.
- Out-of-range p (p>=NUM_PORTS): IN returns 0; OUT and WAIT act as NOP.
- HALT: at the E edge, halted<=1; PC and ir freeze permanently. Only reset clears it.
- Reset (asynchronous assert):
  - PC=0, ir=NOP, W.we=0, all registers=0, Z=0.
  - out_port=0, out_valid=0, halted=0, synchronisers=0.
  - Reset mid-stall or mid-halt has the same effect.
  - First fetch is address 0 on the first edge after deassertion.
- Latency: an instruction fetched at edge n executes through edge n+1. Its result is usable by the next instruction via forwarding.

Optional Feature:
- Macro CPU_CARRY_EN.
- When defined:
  - Carry flag C is set by ADD (carry-out) and SUB (borrow); it is reset to 0.
  - D ADC: rd=ra+rb+C; updates C and Z.
  - E JC: jump if C; forwarded like Z.
- When undefined: no C flop; D and E execute as NOP.

Test Plan:
- Reset, then program LDI r1,5; LDI r2,3; ADD r3,r1,r2; OUT p0,r3:
  - out_port[0]=8 with out_valid[0] strobing exactly once.
  - Verifies back-to-back forwarding.
- LDI r1,7; SUB r2,r1,r1; JZ 6 (skip word 3 at 3); OUT r2 at 6:
  - out_port[0]=0.
  - Skipped instruction never executes (flush check).
  - Taken-jump bubble is 1 cycle.
- WAITR p1 with ready_in[1] low for 10 cycles, then high:
  - PC constant during the wait.
  - Next instruction executes 3 cycles after ready_in rises (sync + E).
- WAITP p0 with ready_in[0] already high on entry:
  - Stays stalled.
  - Low->high toggle releases it exactly once.
- IN r1,p1 with in_port[1]=0xA5; OUT p1,r1; then LDI 0xFF/0x01 ADD:
  - out_port[1]=0xA5.
  - Sum wraps to 0x00 and Z=1.
  - With CPU_CARRY_EN: C=1 and a following ADC r,r0,r0 gives 1.
- HALT at address 3, then assert n_reset low mid-run:
  - halted=1 and PC frozen at 4.
  - Reset returns PC=0, halted=0, out_port=0 immediately (asynchronously).
